// File: rtl/ulpi_pkg.sv
// ulpi_pkg: shared ULPI link-side constants and state encoding.
// Used by the transmit framer and the ULPI receive block.
package ulpi_pkg;

  localparam logic [1:0] TXCMD_TRANSMIT  = 2'b01;
  localparam logic [7:0] ULPI_ABORT_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_STOP,
    ST_DRAIN,
    ST_GAP
  } ulpi_state_t;

  function automatic logic [7:0] txcmd(
    input logic [3:0] pid_lo
  );
    return {TXCMD_TRANSMIT, 2'b00, pid_lo};
  endfunction

endpackage

// File: rtl/ulpi_tx_framer.sv
// ulpi_tx_framer: AXI4-Stream packet -> ULPI transmit (TXCMD, nxt-paced
// data, stp), with dir turnaround, underrun abort and optional IPG.
// Ports: clock/reset (sync, active-high); s_t* packet stream in;
// ulpi_dir_i/ulpi_nxt_i from PHY; ulpi_data_o/ulpi_stp_o to PHY;
// busy_o, underrun_o, lost_o status.
// Macro ULPI_TX_IPG_EN: adds GAP state holding off IPG_CYCLES cycles.
module ulpi_tx_framer
  import ulpi_pkg::*;
#(
  parameter int IPG_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tlast,
  input  logic [7:0] s_tdata,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_stp_o,
  output logic       busy_o,
  output logic       underrun_o,
  output logic       lost_o
);

`ifdef ULPI_TX_IPG_EN
  localparam ulpi_state_t POST = ST_GAP;
  localparam int CW = $clog2(IPG_CYCLES + 1);
  logic [CW-1:0] gap_q;
`else
  localparam ulpi_state_t POST = ST_IDLE;
`endif

  ulpi_state_t state_q;
  logic        last_q;
  logic [7:0]  txcmd_q;
  logic [7:0]  data_q;
  logic        stp_q;
  logic        underrun_q;
  logic        lost_q;
  logic        xfer;

  // Ready never looks at s_tvalid; dir always wins over nxt.
  always_comb begin
    s_tready = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE:  s_tready = !ulpi_dir_i;
        ST_CMD,
        ST_DATA:  s_tready = ulpi_nxt_i && !last_q
                             && !ulpi_dir_i;
        ST_DRAIN: s_tready = 1'b1;
        default:  s_tready = 1'b0;
      endcase
    end
  end

  assign xfer = s_tvalid && s_tready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b0;
      txcmd_q    <= 8'h00;
      data_q     <= 8'h00;
      stp_q      <= 1'b0;
      underrun_q <= 1'b0;
      lost_q     <= 1'b0;
`ifdef ULPI_TX_IPG_EN
      gap_q      <= '0;
`endif
    end else begin
      stp_q      <= 1'b0;
      underrun_q <= 1'b0;
      lost_q     <= 1'b0;
`ifdef ULPI_TX_IPG_EN
      if (state_q != ST_GAP)
        gap_q <= CW'(IPG_CYCLES - 1);
      else if (gap_q != '0)
        gap_q <= gap_q - 1'b1;
`endif
      case (state_q)
        ST_IDLE: begin
          data_q <= 8'h00;
          if (xfer) begin
            data_q  <= txcmd(s_tdata[3:0]);
            txcmd_q <= txcmd(s_tdata[3:0]);
            last_q  <= s_tlast;
            state_q <= ST_CMD;
          end
        end
        ST_CMD, ST_DATA: begin
          if (ulpi_dir_i) begin
            // Turnaround in CMD just defers the TXCMD.
            data_q <= 8'h00;
            if (state_q == ST_DATA) begin
              lost_q  <= 1'b1;
              state_q <= last_q ? POST : ST_DRAIN;
            end
          end else if (ulpi_nxt_i) begin
            if (last_q) begin
              stp_q   <= 1'b1;
              data_q  <= 8'h00;
              state_q <= ST_STOP;
            end else if (s_tvalid) begin
              data_q  <= s_tdata;
              last_q  <= s_tlast;
              state_q <= ST_DATA;
            end else begin
              // Abort with a forced bit-stuff error.
              stp_q      <= 1'b1;
              data_q     <= ULPI_ABORT_BYTE;
              underrun_q <= 1'b1;
              state_q    <= ST_DRAIN;
            end
          end else if (state_q == ST_CMD) begin
            data_q <= txcmd_q;
          end
        end
        ST_STOP: begin
          data_q  <= 8'h00;
          last_q  <= 1'b0;
          state_q <= POST;
        end
        ST_DRAIN: begin
          data_q <= 8'h00;
          last_q <= 1'b0;
          if (xfer && s_tlast)
            state_q <= POST;
        end
        ST_GAP: begin
          data_q <= 8'h00;
`ifdef ULPI_TX_IPG_EN
          if (gap_q == '0)
            state_q <= ST_IDLE;
`else
          state_q <= ST_IDLE;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ulpi_data_o = data_q;
  assign ulpi_stp_o  = stp_q;
  assign underrun_o  = underrun_q;
  assign lost_o      = lost_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ulpi_tx_framer.sv
// tb_ulpi_tx_framer: directed checks of the ULPI transmit framer.
// Covers reset, ACK, streaming, nxt stall, dir turnaround, underrun, IPG.
module tb_ulpi_tx_framer;

  localparam int IPG = 8;
`ifdef ULPI_TX_IPG_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       s_tvalid;
  logic       s_tready;
  logic       s_tlast;
  logic [7:0] s_tdata;
  logic       dir;
  logic       nxt;
  logic [7:0] data;
  logic       stp;
  logic       busy;
  logic       underrun;
  logic       lost;

  int n_chk  = 0;
  int n_fail = 0;
  int n_hs   = 0;
  int n_und  = 0;
  int n_lost = 0;
  int n_stp  = 0;
  int gap;

  always #5 clock = ~clock;

  ulpi_tx_framer #(.IPG_CYCLES(IPG)) dut (
    .clock      (clock),
    .reset      (reset),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tlast    (s_tlast),
    .s_tdata    (s_tdata),
    .ulpi_dir_i (dir),
    .ulpi_nxt_i (nxt),
    .ulpi_data_o(data),
    .ulpi_stp_o (stp),
    .busy_o     (busy),
    .underrun_o (underrun),
    .lost_o     (lost)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic drive(
    input logic       v,
    input logic [7:0] d,
    input logic       l,
    input logic       n,
    input logic       r
  );
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
    nxt      = n;
    dir      = r;
    #1;
  endtask

  task automatic tick();
    if (s_tvalid && s_tready) n_hs++;
    @(posedge clock);
    #1;
    if (underrun) n_und++;
    if (lost) n_lost++;
    if (stp) n_stp++;
  endtask

  task automatic clr();
    n_hs   = 0;
    n_und  = 0;
    n_lost = 0;
    n_stp  = 0;
  endtask

  task automatic wait_idle(input string tag);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40 && busy; i++) tick();
    chk(tag, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_rdy", s_tready, 1'b0);
    tick();
    tick();
    chk("rst_data", data, 8'h00);
    chk("rst_stp", stp, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_und", underrun, 1'b0);
    chk("rst_lost", lost, 1'b0);
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("idle_dir_rdy", s_tready, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("idle_rdy", s_tready, 1'b1);

    // ACK handshake packet
    clr();
    drive(1'b1, 8'hD2, 1'b1, 1'b0, 1'b0);
    tick();
    chk("ack_cmd", data, 8'h42);
    chk("ack_busy", busy, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("ack_rdy", s_tready, 1'b0);
    tick();
    chk("ack_hold", data, 8'h42);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("ack_rdy_nxt", s_tready, 1'b0);
    tick();
    chk("ack_stp", stp, 1'b1);
    chk("ack_stp_data", data, 8'h00);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    chk("ack_stp_end", stp, 1'b0);
    chk("ack_busy_end", busy, GAP_EN);
    wait_idle("ack_idle");

    // DATA0 C3 01 02 with nxt held high
    clr();
    drive(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0);
    tick();
    chk("d0_cmd", data, 8'h43);
    drive(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    tick();
    chk("d0_b1", data, 8'h01);
    drive(1'b1, 8'h02, 1'b1, 1'b1, 1'b0);
    tick();
    chk("d0_b2", data, 8'h02);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("d0_rdy_last", s_tready, 1'b0);
    tick();
    chk("d0_stp", stp, 1'b1);
    chk("d0_hs", n_hs, 3);
    wait_idle("d0_idle");
    chk("d0_und", n_und, 0);
    chk("d0_lost", n_lost, 0);

    // nxt delayed 4 cycles after TXCMD
    clr();
    drive(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("dly_cmd", data, 8'h43);
      drive(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
      chk("dly_rdy", s_tready, 1'b0);
      tick();
    end
    chk("dly_cmd4", data, 8'h43);
    drive(1'b1, 8'hAA, 1'b1, 1'b1, 1'b0);
    chk("dly_rdy_nxt", s_tready, 1'b1);
    tick();
    chk("dly_b1", data, 8'hAA);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    chk("dly_stp", stp, 1'b1);
    wait_idle("dly_idle");
    chk("dly_hs", n_hs, 2);

    // dir high for 3 cycles during CMD
    clr();
    drive(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    tick();
    chk("dc_cmd", data, 8'h43);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
      chk("dc_rdy", s_tready, 1'b0);
      tick();
      chk("dc_zero", data, 8'h00);
    end
    drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    tick();
    chk("dc_recmd", data, 8'h43);
    drive(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    tick();
    chk("dc_b1", data, 8'h55);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    chk("dc_stp", stp, 1'b1);
    wait_idle("dc_idle");
    chk("dc_lost", n_lost, 0);

    // dir rising in DATA
    clr();
    drive(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    tick();
    chk("dd_b1", data, 8'h11);
    drive(1'b1, 8'h22, 1'b0, 1'b1, 1'b1);
    chk("dd_rdy_dir", s_tready, 1'b0);
    tick();
    chk("dd_lost", lost, 1'b1);
    chk("dd_data", data, 8'h00);
    drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    chk("dd_drain_rdy", s_tready, 1'b1);
    tick();
    chk("dd_lost_end", lost, 1'b0);
    drive(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    tick();
    wait_idle("dd_idle");
    chk("dd_hs", n_hs, 4);
    chk("dd_nostp", n_stp, 0);
    chk("dd_lostcnt", n_lost, 1);

    // underrun after byte 2 of 5
    clr();
    drive(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    tick();
    chk("ur_b1", data, 8'h01);
    drive(1'b0, 8'h02, 1'b0, 1'b1, 1'b0);
    tick();
    chk("ur_stp", stp, 1'b1);
    chk("ur_ff", data, 8'hFF);
    chk("ur_pulse", underrun, 1'b1);
    drive(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    tick();
    chk("ur_stp_end", stp, 1'b0);
    chk("ur_pulse_end", underrun, 1'b0);
    drive(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    tick();
    chk("ur_drain_busy", busy, 1'b1);
    drive(1'b1, 8'h04, 1'b1, 1'b0, 1'b0);
    tick();
    chk("ur_post_busy", busy, GAP_EN);
    wait_idle("ur_idle");
    chk("ur_hs", n_hs, 5);
    chk("ur_cnt", n_und, 1);

    // back-to-back handshakes: gap from stp to next PID
    clr();
    drive(1'b1, 8'hD2, 1'b1, 1'b1, 1'b0);
    tick();
    chk("bb_cmd1", data, 8'h42);
    drive(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
    tick();
    chk("bb_stp1", stp, 1'b1);
    chk("bb_rdy_stp", s_tready, 1'b0);
    tick();
    gap = 0;
    while (!s_tready && gap < 40) begin
      gap++;
      tick();
    end
    chk("bb_gap", gap, GAP_EN ? IPG : 0);
    tick();
    chk("bb_cmd2", data, 8'h4A);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    chk("bb_stp2", stp, 1'b1);
    wait_idle("bb_idle");

    // reset mid-packet
    drive(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    tick();
    chk("mr_b1", data, 8'h01);
    reset = 1'b1;
    drive(1'b1, 8'h02, 1'b0, 1'b1, 1'b0);
    chk("mr_rdy", s_tready, 1'b0);
    tick();
    chk("mr_data", data, 8'h00);
    chk("mr_stp", stp, 1'b0);
    chk("mr_busy", busy, 1'b0);
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ulpi_tx_framer.md
# ulpi_tx_framer

Converts the device's transmit AXI4-Stream (the USB protocol layer's `usb_tvalid_o`/`usb_tlast_o`/`usb_tdata_o` output, one packet per frame, PID first) into ULPI link-side transmit signalling. It sits directly downstream of the protocol layer and drives the ULPI PHY: TXCMD, data bytes paced by `nxt`, and `stp`. It also handles bus turnaround (`dir`), underrun aborts and the inter-packet gap. Bidirectional pad tristating and ULPI receive are done elsewhere.

## Interface

Parameters:
- `IPG_CYCLES`, default 8: minimum idle cycles after `stp` before the next TXCMD. Used only with `ULPI_TX_IPG_EN`.

Ports:
- `clock` in 1: 60 MHz ULPI clock; single clock domain.
- `reset` in 1: synchronous, active-high.
- `s_tvalid` in 1: packet byte valid.
- `s_tready` out 1: byte consumed.
- `s_tlast` in 1: last byte of packet.
- `s_tdata` in 8: packet byte; the first byte of a frame is the PID.
- `ulpi_dir_i` in 1: PHY owns bus when high.
- `ulpi_nxt_i` in 1: PHY throttle/accept.
- `ulpi_data_o` out 8: link-driven data (valid when `ulpi_dir_i` low).
- `ulpi_stp_o` out 1: end/abort of transmit.
- `busy_o` out 1: transmit in progress (any state but IDLE).
- `underrun_o` out 1: one-cycle pulse on an underrun abort.
- `lost_o` out 1: one-cycle pulse when `dir` rises mid-packet.

## Operation

- States: IDLE, CMD, DATA, STOP, DRAIN, GAP (GAP exists only with the macro).
- TXCMD byte = `8'h40 | s_tdata[3:0]`, taken from the PID byte.
- **IDLE:** `s_tready = !ulpi_dir_i`. On a transfer, register the TXCMD onto `ulpi_data_o` and go to CMD. Record `s_tlast` into `last_q`.
- **CMD:** hold TXCMD until `ulpi_nxt_i`.
  - If `ulpi_dir_i` is high before `nxt`, drive `8'h00` while dir is high. Stay in CMD and re-present the same TXCMD after dir falls. This is not an error.
  - When `nxt` is high: if `last_q`, go to STOP; otherwise go to DATA.
- **DATA/CMD byte advance:** `s_tready = ulpi_nxt_i && !last_q && !ulpi_dir_i` (combinational from `nxt`). A transfer loads `s_tdata` into `ulpi_data_o` on the next cycle and updates `last_q`.
  - In DATA, `nxt` high with `last_q` set goes to STOP.
  - In DATA, `nxt` high with no `s_tvalid` is an underrun:
    - Next cycle: `ulpi_stp_o = 1`, `ulpi_data_o = 8'hFF` (forced bit-stuff error).
    - Pulse `underrun_o`.
    - Go to DRAIN.
  - In DATA, `ulpi_dir_i` high: pulse `lost_o`, go to DRAIN, drive `8'h00`.
- **STOP:** for one cycle `ulpi_stp_o = 1`, `ulpi_data_o = 8'h00`. Then go to GAP, or to IDLE without the macro.
- **DRAIN:** `s_tready = 1`. Discard bytes through the `s_tlast` transfer, then go to GAP/IDLE. `stp` is asserted only on the entry cycle, and only for an underrun.
- **GAP:** count `IPG_CYCLES` down to 0, then go to IDLE. `s_tready = 0`.

## Timing

- Reset values: `ulpi_data_o = 8'h00`, `ulpi_stp_o = 0`, `s_tready = 0` (held low during the reset cycle regardless of dir), `busy_o = 0`, `underrun_o = 0`, `lost_o = 0`, `last_q = 0`, state IDLE.
- `reset` asserted mid-packet: outputs go to their reset values on the next edge. No `stp` is emitted. Upstream is expected to be reset in the same cycle.
- Latency from the PID transfer to TXCMD on the bus: 1 cycle.
- Latency from the `nxt` that accepts the last byte to `stp`: 1 cycle.
- `ulpi_data_o` and `ulpi_stp_o` are registered.
- `s_tready` is combinational from `nxt`/`dir` and registered state only, never from `s_tvalid`.
- Upstream must keep `s_tvalid` high within a frame; any gap sampled on an `nxt` cycle is an underrun.
- `dir` and `nxt` both high in the same cycle is treated as dir: no byte is consumed.
- A one-byte packet (handshake): TXCMD, `nxt`, then `stp` on the next cycle.

## Configuration

- `ULPI_TX_IPG_EN` defined: the GAP state and an `$clog2(IPG_CYCLES+1)`-bit down-counter are compiled in. `s_tready` stays low for `IPG_CYCLES` cycles after STOP/DRAIN.
- Not defined: STOP/DRAIN return directly to IDLE, so the next TXCMD can appear 2 cycles after `stp`. `IPG_CYCLES` is ignored.

## Structure

- Shared package `ulpi_pkg`:
  - `TXCMD_TRANSMIT = 2'b01` prefix.
  - `ULPI_ABORT_BYTE = 8'hFF`.
  - The state enum typedef, also used by the ULPI receive block.
- No sub-module. The gap counter is inline under the macro.

## Test plan

- **ACK:** single byte `8'hD2` with `tlast`, `nxt` one cycle after TXCMD → `ulpi_data_o = 8'h42`, then `stp = 1` with data `00` for one cycle; `busy_o` falls the cycle after `stp`.
- **DATA0 `C3 01 02`, `nxt` held high** → bus sequence `43, 01, 02`, then `stp`; 3 `s_tready` handshakes total; no pulses on `underrun_o` or `lost_o`.
- **TXCMD `43` with `nxt` delayed 4 cycles** → TXCMD held 4 cycles, `s_tready` low throughout, then sequence resumes normally.
- **`dir` high 3 cycles during CMD** → data `00` while dir is high, TXCMD `43` re-presented afterwards, packet completes. **`dir` rising in DATA instead** → `lost_o` pulse, remaining bytes drained, no `stp`.
- **`s_tvalid` low on an `nxt` cycle after byte 2 of 5** → `stp = 1` with `ulpi_data_o = FF`, `underrun_o` pulse, remaining 3 bytes drained through `tlast`, then IDLE.
- **With `ULPI_TX_IPG_EN`, `IPG_CYCLES = 8`, back-to-back packets** → 8 cycles of `s_tready = 0` between `stp` and the next PID acceptance.
